// File: rtl/router_pkg.sv
// Shared types and default memory map for the core-side memory router.
package router_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ERR
  } router_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] top;
  } region_t;

  // Default map: block RAM, print console, core-local interruptor
  localparam region_t BRAM_REGION  = '{base: 32'h0000000, top: 32'h0100000};
  localparam region_t PRINT_REGION = '{base: 32'h1000000, top: 32'h1000004};
  localparam region_t CLINT_REGION = '{base: 32'h2000000, top: 32'h200C000};

  // Base is inclusive, top is exclusive, both unsigned
  function automatic logic in_region(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] top);
    return (addr >= base) && (addr < top);
  endfunction

endpackage

// File: rtl/region_decode.sv
// Combinational priority decode of an address into a one-hot region select.
module region_decode
  import router_pkg::*;
#(
  parameter int unsigned       NUM_REGION = 3,
  parameter logic [ADDR_W-1:0] REGION_BASE [NUM_REGION] =
    '{BRAM_REGION.base, PRINT_REGION.base, CLINT_REGION.base},
  parameter logic [ADDR_W-1:0] REGION_TOP  [NUM_REGION] =
    '{BRAM_REGION.top, PRINT_REGION.top, CLINT_REGION.top}
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_REGION-1:0] sel_c,
  output logic                  hit_c
);

  // Scan from the highest index down so the lowest matching region wins
  always_comb begin
    sel_c = '0;
    hit_c = 1'b0;
    for (int i = int'(NUM_REGION) - 1; i >= 0; i--) begin
      if (in_region(addr, REGION_BASE[i], REGION_TOP[i])) begin
        sel_c    = '0;
        sel_c[i] = 1'b1;
        hit_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_router.sv
// Routes the core's single memory request port to one of NUM_REGION slave
// channels, with error responses for unmapped addresses and silent slaves.
module memory_router
  import router_pkg::*;
#(
  parameter int unsigned       NUM_REGION = 3,
  parameter logic [ADDR_W-1:0] REGION_BASE [NUM_REGION] =
    '{BRAM_REGION.base, PRINT_REGION.base, CLINT_REGION.base},
  parameter logic [ADDR_W-1:0] REGION_TOP  [NUM_REGION] =
    '{BRAM_REGION.top, PRINT_REGION.top, CLINT_REGION.top},
  parameter int unsigned       TIMEOUT    = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             m_valid,
  input  logic                             m_instr,
  input  logic [ADDR_W-1:0]                m_addr,
  input  logic [DATA_W-1:0]                m_wdata,
  input  logic [STRB_W-1:0]                m_wstrb,
  output logic                             m_ready,
  output logic [DATA_W-1:0]                m_rdata,
  output logic                             m_error,
  output logic                             protocol_err,
  output logic [NUM_REGION-1:0]            s_valid,
  output logic                             s_instr,
  output logic [ADDR_W-1:0]                s_addr,
  output logic [DATA_W-1:0]                s_wdata,
  output logic [STRB_W-1:0]                s_wstrb,
  input  logic [NUM_REGION-1:0]            s_ready,
  input  logic [NUM_REGION-1:0][DATA_W-1:0] s_rdata
);

  localparam int unsigned     CNT_W      = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(TIMEOUT - 2);

  router_state_t          state;
  logic [NUM_REGION-1:0]  sel_q;
  logic [CNT_W-1:0]       cnt;

  logic [NUM_REGION-1:0]  dec_sel_c;
  logic                   dec_hit_c;
  logic                   ready_hit_c;
  logic [DATA_W-1:0]      rdata_mux_c;

  region_decode #(
    .NUM_REGION  (NUM_REGION),
    .REGION_BASE (REGION_BASE),
    .REGION_TOP  (REGION_TOP)
  ) u_decode (
    .addr  (m_addr),
    .sel_c (dec_sel_c),
    .hit_c (dec_hit_c)
  );

  // Only the selected channel may complete the transaction
  assign ready_hit_c = |(s_ready & sel_q);

  always_comb begin
    rdata_mux_c = '0;
    for (int i = 0; i < int'(NUM_REGION); i++) begin
      if (sel_q[i]) rdata_mux_c = rdata_mux_c | s_rdata[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      sel_q        <= '0;
      cnt          <= '0;
      m_ready      <= 1'b0;
      m_rdata      <= '0;
      m_error      <= 1'b0;
      protocol_err <= 1'b0;
      s_valid      <= '0;
      s_instr      <= 1'b0;
      s_addr       <= '0;
      s_wdata      <= '0;
      s_wstrb      <= '0;
    end else begin
      s_valid <= '0;
      m_ready <= 1'b0;
      m_error <= 1'b0;

      if (m_valid && (state != ST_IDLE)) protocol_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (m_valid) begin
            s_instr <= m_instr;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_wstrb <= m_wstrb;
            sel_q   <= dec_sel_c;
            if (dec_hit_c) begin
              s_valid <= dec_sel_c;
              state   <= ST_REQ;
            end else begin
              state   <= ST_ERR;
            end
          end
        end

        ST_REQ: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end

        // A response in the last waiting cycle beats the timeout
        ST_WAIT: begin
          if (ready_hit_c) begin
            m_ready <= 1'b1;
            m_rdata <= rdata_mux_c;
            state   <= ST_IDLE;
          end else begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (cnt >= CNT_EXPIRE) state <= ST_ERR;
          end
        end

        ST_ERR: begin
          m_ready <= 1'b1;
          m_error <= 1'b1;
          m_rdata <= '0;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_router.sv
// Directed scoreboard bench for memory_router with a short timeout and an
// overlapping-map instance.
module tb_memory_router;
  import router_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned TO = 8;
  localparam logic [31:0] OV_BASE [2] = '{32'h000, 32'h080};
  localparam logic [31:0] OV_TOP  [2] = '{32'h200, 32'h180};

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic              m_valid = 1'b0;
  logic              m_instr = 1'b0;
  logic [31:0]       m_addr  = '0;
  logic [31:0]       m_wdata = '0;
  logic [3:0]        m_wstrb = '0;
  logic              m_ready;
  logic [31:0]       m_rdata;
  logic              m_error;
  logic              protocol_err;
  logic [NR-1:0]     s_valid;
  logic              s_instr;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic [NR-1:0]     s_ready = '0;
  logic [NR-1:0][31:0] s_rdata = '0;

  logic              ov_valid = 1'b0;
  logic [31:0]       ov_addr  = '0;
  logic              ov_m_ready;
  logic [31:0]       ov_m_rdata;
  logic              ov_m_error;
  logic              ov_protocol_err;
  logic [1:0]        ov_s_valid;
  logic              ov_s_instr;
  logic [31:0]       ov_s_addr;
  logic [31:0]       ov_s_wdata;
  logic [3:0]        ov_s_wstrb;
  logic [1:0]        ov_s_ready = '0;
  logic [1:0][31:0]  ov_s_rdata = '0;

  int    checks = 0;
  int    errors = 0;
  resp_t exp_q[$];

  always #5 clock = ~clock;

  memory_router #(.NUM_REGION(NR), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .m_valid      (m_valid),
    .m_instr      (m_instr),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_ready      (m_ready),
    .m_rdata      (m_rdata),
    .m_error      (m_error),
    .protocol_err (protocol_err),
    .s_valid      (s_valid),
    .s_instr      (s_instr),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_ready      (s_ready),
    .s_rdata      (s_rdata)
  );

  memory_router #(
    .NUM_REGION(2), .REGION_BASE(OV_BASE), .REGION_TOP(OV_TOP), .TIMEOUT(4)
  ) dut_ov (
    .clock        (clock),
    .reset        (reset),
    .m_valid      (ov_valid),
    .m_instr      (m_instr),
    .m_addr       (ov_addr),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_ready      (ov_m_ready),
    .m_rdata      (ov_m_rdata),
    .m_error      (ov_m_error),
    .protocol_err (ov_protocol_err),
    .s_valid      (ov_s_valid),
    .s_instr      (ov_s_instr),
    .s_addr       (ov_s_addr),
    .s_wdata      (ov_s_wdata),
    .s_wstrb      (ov_s_wstrb),
    .s_ready      (ov_s_ready),
    .s_rdata      (ov_s_rdata)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle request; returns in the cycle after it was sampled
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic instr);
    m_addr  = addr;
    m_wdata = wdata;
    m_wstrb = wstrb;
    m_instr = instr;
    m_valid = 1'b1;
    step();
    m_valid = 1'b0;
  endtask

  // Pulse s_ready on the given channels; other channels carry decoy data
  task automatic answer(input logic [NR-1:0] onehot, input logic [31:0] data);
    for (int c = 0; c < int'(NR); c++) s_rdata[c] = onehot[c] ? data : ~data;
    s_ready = onehot;
    step();
    s_ready = '0;
  endtask

  task automatic expect_resp(input string tag);
    resp_t e;
    chk({tag, "_ready"}, 32'(m_ready), 32'd1);
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected pending entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, m_rdata, e.rdata);
      chk({tag, "_error"}, 32'(m_error), 32'(e.err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected $finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0]   dec_addr [6];
  logic [NR-1:0] dec_sel  [6];
  int            n;

  initial begin
    dec_addr = '{32'h00FFFFC, 32'h0100000, 32'h1000003,
                 32'h1000004, 32'h200BFFF, 32'h200C000};
    dec_sel  = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};

    step();
    step();
    reset = 1'b0;
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_m_error", 32'(m_error), 32'd0);
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_prot", 32'(protocol_err), 32'd0);

    // Read from BRAM, answered two cycles after s_valid
    issue(32'h10, 32'h0, 4'h0, 1'b0);
    chk("rd_s_valid", 32'(s_valid), 32'b001);
    chk("rd_s_addr", s_addr, 32'h10);
    chk("rd_s_wstrb", 32'(s_wstrb), 32'h0);
    exp_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    step();
    chk("rd_s_valid_pulse", 32'(s_valid), 32'd0);
    answer(3'b001, 32'hDEADBEEF);
    expect_resp("rd");
    step();
    chk("rd_ready_pulse", 32'(m_ready), 32'd0);

    // Write to the print console with minimum latency
    issue(32'h1000000, 32'h41, 4'hF, 1'b1);
    chk("wr_s_valid", 32'(s_valid), 32'b010);
    chk("wr_s_wdata", s_wdata, 32'h41);
    chk("wr_s_wstrb", 32'(s_wstrb), 32'hF);
    chk("wr_s_instr", 32'(s_instr), 32'd1);
    exp_q.push_back('{rdata: 32'hCAFE0001, err: 1'b0});
    step();
    answer(3'b010, 32'hCAFE0001);
    expect_resp("wr");

    // Unmapped access issued in the same cycle as the previous response
    issue(32'h3000000, 32'h0, 4'h0, 1'b0);
    chk("um_s_valid1", 32'(s_valid), 32'd0);
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    step();
    chk("um_s_valid2", 32'(s_valid), 32'd0);
    expect_resp("um");

    // Region edges: last byte in, first byte past top
    for (int t = 0; t < 6; t++) begin
      issue(dec_addr[t], 32'h0, 4'h0, 1'b0);
      chk($sformatf("edge%0d_s_valid", t), 32'(s_valid), 32'(dec_sel[t]));
      if (dec_sel[t] != '0) begin
        exp_q.push_back('{rdata: dec_addr[t] ^ 32'h5A5A0000, err: 1'b0});
        step();
        answer(dec_sel[t], dec_addr[t] ^ 32'h5A5A0000);
      end else begin
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        step();
      end
      expect_resp($sformatf("edge%0d", t));
    end

    // Timeout on a silent CLINT access
    issue(32'h2000004, 32'h0, 4'h0, 1'b0);
    chk("to_s_valid", 32'(s_valid), 32'b100);
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    n = 1;
    while (m_ready !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("to_cycle", 32'(n), 32'(TO + 2));
    expect_resp("to");
    answer(3'b100, 32'h00000BAD);
    chk("to_stray_ready", 32'(m_ready), 32'd0);
    step();
    chk("to_stray_ready2", 32'(m_ready), 32'd0);

    // Response on the last waiting cycle, after a non-selected s_ready
    issue(32'h2000004, 32'h0, 4'h0, 1'b0);
    exp_q.push_back('{rdata: 32'h0000600D, err: 1'b0});
    step();
    answer(3'b001, 32'h11110000);
    chk("exp_nonsel_ready", 32'(m_ready), 32'd0);
    for (int c = 3; c < int'(TO); c++) step();
    chk("exp_last_wait", 32'(m_ready), 32'd0);
    answer(3'b100, 32'h0000600D);
    expect_resp("exp");
    step();
    chk("exp_no_err_pulse", 32'(m_ready), 32'd0);

    // Request while busy is dropped and flagged
    chk("pe_before", 32'(protocol_err), 32'd0);
    issue(32'h10, 32'h0, 4'h0, 1'b0);
    step();
    m_addr  = 32'h1000000;
    m_valid = 1'b1;
    step();
    m_valid = 1'b0;
    chk("pe_set", 32'(protocol_err), 32'd1);
    chk("pe_no_s_valid", 32'(s_valid), 32'd0);
    exp_q.push_back('{rdata: 32'h11112222, err: 1'b0});
    answer(3'b001, 32'h11112222);
    expect_resp("pe");
    chk("pe_sticky", 32'(protocol_err), 32'd1);
    step();
    chk("pe_dropped_s_valid", 32'(s_valid), 32'd0);
    chk("pe_dropped_ready", 32'(m_ready), 32'd0);

    // Reset while waiting, then a late answer
    issue(32'h10, 32'h0, 4'h0, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_m_ready", 32'(m_ready), 32'd0);
    chk("mr_m_rdata", m_rdata, 32'd0);
    chk("mr_m_error", 32'(m_error), 32'd0);
    chk("mr_s_valid", 32'(s_valid), 32'd0);
    chk("mr_s_addr", s_addr, 32'd0);
    chk("mr_prot", 32'(protocol_err), 32'd0);
    answer(3'b001, 32'h77777777);
    chk("mr_late_ready", 32'(m_ready), 32'd0);
    step();
    chk("mr_late_ready2", 32'(m_ready), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    // Overlapping map: the lower index wins
    ov_addr  = 32'h100;
    ov_valid = 1'b1;
    step();
    ov_valid = 1'b0;
    chk("ov_s_valid", 32'(ov_s_valid), 32'b01);
    for (int c = 0; c < 10; c++) step();
    ov_addr  = 32'h250;
    ov_valid = 1'b1;
    step();
    ov_valid = 1'b0;
    chk("ov_unmapped", 32'(ov_s_valid), 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
